// File: rtl/unpack_u32_stream.sv
// Byte-serial LEB128 decoder for unsigned 32-bit values.
// Accumulates 7-bit groups LSB-first and emits one word per encoded value.
module unpack_u32_stream (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        i_ready,
  output logic [31:0] o_data,
  output logic [2:0]  o_len,
  output logic        o_err,
  output logic        o_valid,
  input  logic        o_ready
);

  typedef enum logic {
    ACC,
    SKIP
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  k, k_nx;
  logic [31:0] acc, acc_nx;
  logic [31:0] merged;
  logic [31:0] o_data_nx;
  logic [2:0]  o_len_nx;
  logic        o_err_nx;
  logic        o_valid_nx;
  logic        accept;
  logic        pop;

  // SKIP always drains input; ACC needs the one-entry output slot free or popping
  assign i_ready = (state == SKIP) || !o_valid || o_ready;
  assign accept  = i_valid && i_ready;
  assign pop     = o_valid && o_ready;

  // The fifth group only has room for four bits of a 32-bit value
  always_comb begin
    merged = acc;
    case (k)
      3'd0:    merged[6:0]   = i_data[6:0];
      3'd1:    merged[13:7]  = i_data[6:0];
      3'd2:    merged[20:14] = i_data[6:0];
      3'd3:    merged[27:21] = i_data[6:0];
      3'd4:    merged[31:28] = i_data[3:0];
      default: merged        = acc;
    endcase
  end

  always_comb begin
    state_nx   = state;
    k_nx       = k;
    acc_nx     = acc;
    o_data_nx  = o_data;
    o_len_nx   = o_len;
    o_err_nx   = o_err;
    o_valid_nx = o_valid;

    if (pop) begin
      o_valid_nx = 1'b0;
    end

    if (accept) begin
      case (state)
        ACC: begin
          if (!i_data[7]) begin
            o_data_nx  = merged;
            o_len_nx   = k + 3'd1;
            o_err_nx   = (k == 3'd4) && (i_data[6:4] != 3'd0);
            o_valid_nx = 1'b1;
            acc_nx     = 32'd0;
            k_nx       = 3'd0;
          end else if (k == 3'd4) begin
            // Overlong: report what fits, then throw away the rest of the encoding
            o_data_nx  = merged;
            o_len_nx   = 3'd5;
            o_err_nx   = 1'b1;
            o_valid_nx = 1'b1;
            acc_nx     = 32'd0;
            k_nx       = 3'd0;
            state_nx   = SKIP;
          end else begin
            acc_nx = merged;
            k_nx   = k + 3'd1;
          end
        end
        SKIP: begin
          if (!i_data[7]) begin
            state_nx = ACC;
          end
        end
        default: state_nx = ACC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACC;
      k       <= 3'd0;
      acc     <= 32'd0;
      o_data  <= 32'd0;
      o_len   <= 3'd0;
      o_err   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      k       <= k_nx;
      acc     <= acc_nx;
      o_data  <= o_data_nx;
      o_len   <= o_len_nx;
      o_err   <= o_err_nx;
      o_valid <= o_valid_nx;
    end
  end

endmodule

// File: tb/tb_unpack_u32_stream.sv
// Testbench for unpack_u32_stream: directed cases from the decoder's rules plus
// randomized byte streams checked against a byte-list LEB128 reference model.
module tb_unpack_u32_stream;

  logic        clk;
  logic        rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [2:0]  o_len;
  logic        o_err;
  logic        o_valid;
  logic        o_ready;

  int checks;
  int failures;

  typedef struct packed {
    logic        err;
    logic [2:0]  len;
    logic [31:0] data;
  } word_t;

  word_t      expQ[$];
  logic [7:0] curBytes[$];
  bit         modelSkip;

  unpack_u32_stream dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_len   (o_len),
    .o_err   (o_err),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decoder: collect the bytes of one value, then sum the groups arithmetically
  function automatic void modelByte(input logic [7:0] b);
    longint unsigned val;
    word_t           w;
    if (modelSkip) begin
      if (!b[7]) modelSkip = 1'b0;
      return;
    end
    curBytes.push_back(b);
    if (!b[7] || curBytes.size() == 5) begin
      val = 0;
      for (int i = 0; i < curBytes.size(); i++)
        val += longint'(curBytes[i][6:0]) << (7 * i);
      w.data = val[31:0];
      w.len  = 3'(curBytes.size());
      w.err  = b[7] || (curBytes.size() == 5 && b[6:4] != 3'd0);
      if (b[7]) modelSkip = 1'b1;
      expQ.push_back(w);
      curBytes.delete();
    end
  endfunction

  function automatic void modelReset();
    expQ.delete();
    curBytes.delete();
    modelSkip = 1'b0;
  endfunction

  // One clock cycle: drive at the falling edge, check, then commit the model after the rising edge
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r,
                               input logic rs, output logic accepted);
    logic popped;
    logic expReady;
    i_valid = v;
    i_data  = d;
    o_ready = r;
    rst     = rs;
    #1;
    expReady = modelSkip || (expQ.size() == 0) || r;
    checkOutput("i_ready", 32'(i_ready), 32'(expReady));
    checkOutput("o_valid", 32'(o_valid), 32'(expQ.size() != 0));
    if (expQ.size() != 0) begin
      checkOutput("o_data", o_data, expQ[0].data);
      checkOutput("o_len", 32'(o_len), 32'(expQ[0].len));
      checkOutput("o_err", 32'(o_err), 32'(expQ[0].err));
    end
    accepted = !rs && v && i_ready;
    popped   = !rs && o_valid && r;
    @(posedge clk);
    if (rs) begin
      modelReset();
    end else begin
      if (popped) void'(expQ.pop_front());
      if (accepted) modelByte(d);
    end
    @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] d, input logic r);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++)
      applyStimulus(1'b1, d, r, 1'b0, acc);
    if (!acc) checkOutput("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, acc);
  endtask

  task automatic checkWord(input string tag, input logic [31:0] d, input logic [2:0] l, input logic e);
    checkOutput({tag, "_valid"}, 32'(o_valid), 32'd1);
    checkOutput({tag, "_data"}, o_data, d);
    checkOutput({tag, "_len"}, 32'(o_len), 32'(l));
    checkOutput({tag, "_err"}, 32'(o_err), 32'(e));
  endtask

  initial begin
    logic acc;
    logic [7:0] b;
    checks    = 0;
    failures  = 0;
    modelSkip = 1'b0;
    rst       = 1'b1;
    i_valid   = 1'b0;
    i_data    = 8'h00;
    o_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_o_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_o_data", o_data, 32'd0);
    checkOutput("rst_o_len", 32'(o_len), 32'd0);
    checkOutput("rst_o_err", 32'(o_err), 32'd0);
    checkOutput("rst_i_ready", 32'(i_ready), 32'd1);

    // Single byte, one cycle latency
    sendByte(8'h05, 1'b1);
    checkWord("single", 32'd5, 3'd1, 1'b0);
    idle(1);

    sendByte(8'hE5, 1'b1);
    sendByte(8'h8E, 1'b1);
    sendByte(8'h26, 1'b1);
    checkWord("three", 32'h00098765, 3'd3, 1'b0);
    idle(1);

    for (int i = 0; i < 4; i++) sendByte(8'hFF, 1'b1);
    sendByte(8'h0F, 1'b1);
    checkWord("max", 32'hFFFFFFFF, 3'd5, 1'b0);
    for (int i = 0; i < 4; i++) sendByte(8'hFF, 1'b1);
    sendByte(8'h1F, 1'b1);
    checkWord("ovf", 32'hFFFFFFFF, 3'd5, 1'b1);
    idle(1);

    for (int i = 0; i < 5; i++) sendByte(8'h80, 1'b1);
    checkWord("overlong", 32'd0, 3'd5, 1'b1);
    sendByte(8'h80, 1'b1);
    sendByte(8'h00, 1'b1);
    sendByte(8'h07, 1'b1);
    checkWord("after_skip", 32'd7, 3'd1, 1'b0);
    idle(1);

    sendByte(8'h80, 1'b1);
    sendByte(8'h00, 1'b1);
    checkWord("nonminimal", 32'd0, 3'd2, 1'b0);
    idle(1);

    // Backpressure holds the first word and blocks the second byte
    sendByte(8'h01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, acc);
      checkOutput("bp_no_accept", 32'(acc), 32'd0);
      checkWord("bp_hold", 32'd1, 3'd1, 1'b0);
    end
    sendByte(8'h02, 1'b1);
    checkWord("bp_second", 32'd2, 3'd1, 1'b0);
    idle(1);

    sendByte(8'h80, 1'b1);
    sendByte(8'h81, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, acc);
    checkOutput("midrst_o_valid", 32'(o_valid), 32'd0);
    checkOutput("midrst_o_data", o_data, 32'd0);
    checkOutput("midrst_o_len", 32'(o_len), 32'd0);
    sendByte(8'h03, 1'b1);
    checkWord("after_rst", 32'd3, 3'd1, 1'b0);
    idle(1);

    // Random streams with random handshakes and occasional reset
    for (int i = 0; i < 1500; i++) begin
      b = 8'($urandom);
      b[7] = ($urandom_range(0, 9) < 6);
      applyStimulus(($urandom_range(0, 9) < 8), b, ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 199) == 0), acc);
    end

    for (int n = 0; n < 10 && expQ.size() != 0; n++) idle(1);
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unpack_u32_stream.md
# unpack_u32_stream

Byte-serial LEB128 decoder for unsigned 32-bit values; the receive-side counterpart of the combinational u32 LEB128 packer. It consumes one encoded byte per cycle over a valid/ready stream, accumulates 7-bit groups LSB-first, and emits one decoded 32-bit word with its byte length and an error flag per encoded value. It sits between a byte-stream source (e.g. a deserialiser or FIFO) and word-level consumers.

## Interface
- No parameters; data width fixed at 32 bits, max encoded length 5 bytes.
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- i_data  input  8  encoded byte; bit 7 = continuation, bits 6:0 = payload group
- i_valid  input  1  i_data valid
- i_ready  output  1  block accepts i_data this cycle
- o_data  output  32  decoded value
- o_len  output  3  bytes consumed for this value, 1..5
- o_err  output  1  value malformed (overflow or overlong)
- o_valid  output  1  o_data/o_len/o_err valid
- o_ready  input  1  consumer accepts output this cycle

## Operation
- Byte accepted when i_valid && i_ready; word popped when o_valid && o_ready.
- States: ACC (accumulating), SKIP (discarding the tail of an overlong encoding).
- ACC: byte index k (0..4) and accumulator acc[31:0]. On accept, acc[7k+6:7k] = i_data[6:0]; for k=4 only i_data[3:0] lands in acc[31:28].
- Terminal byte (i_data[7]=0) in ACC: load o_data = acc merged with the byte, o_len = k+1, o_err = (k==4 && i_data[6:4]!=0), set o_valid, clear acc and k.
- Non-terminal byte with k<4: k increments, no output.
- Non-terminal byte with k==4 (overlong): emit o_data = merged acc (upper bits truncated as above), o_len = 5, o_err = 1; go to SKIP.
- SKIP: i_ready = 1 regardless of output state; every accepted byte is discarded; a byte with bit 7 = 0 is discarded and returns the block to ACC with k=0, acc=0.
- ACC: i_ready = !o_valid || o_ready (one-entry output register with same-cycle pop-and-reload).
- Non-minimal encodings (e.g. 0x80 0x00) are legal: value 0, o_len 2, o_err 0.
- o_data/o_len/o_err hold stable while o_valid && !o_ready; they change only on load.

## Timing
- Reset values: o_valid 0, o_data 0, o_len 0, o_err 0, state ACC, k 0, acc 0; i_ready 1 in the cycle after reset deasserts.
- Latency: terminal byte accepted in cycle N → o_valid high in cycle N+1.
- Throughput: one byte per cycle with o_ready held high; back-to-back single-byte values produce o_valid high every cycle.
- Simultaneous pop and terminal-byte accept: o_valid stays high, fields take the new value next cycle.
- Backpressure: while o_valid && !o_ready in ACC, i_ready = 0 and no byte is consumed; partial acc/k preserved.
- Entering SKIP with o_valid already high and unpopped: the overlong result is not dropped; transition to SKIP happens only on the cycle the overlong byte is accepted, which requires the output slot free.
- rst mid-value or in SKIP: partial accumulation and pending output discarded; first byte after reset starts a new value.
- i_data is ignored when i_valid = 0; no state changes.

## Test plan
- Single byte 0x05, o_ready=1 → next cycle o_valid=1, o_data=5, o_len=1, o_err=0.
- Bytes 0xE5 0x8E 0x26 back-to-back → o_data=624485 (0x00098765), o_len=3, o_err=0, o_valid one cycle after 0x26.
- 0xFF 0xFF 0xFF 0xFF 0x0F → 0xFFFFFFFF, len 5, err 0; repeat with last byte 0x1F → 0xFFFFFFFF, len 5, err 1.
- 0x80 ×5 then 0x80 0x00, then 0x07 → one word (0, len 5, err 1), SKIP discards 0x80 0x00, then word 7, len 1, err 0.
- o_ready=0, stream 0x01 0x02 → first word held stable, i_ready=0 until o_ready rises; then words 1 and 2 in order, none lost or duplicated.
- Bytes 0x80 0x81, assert rst one cycle, then 0x03 → only word 3, len 1, err 0; all outputs zero during/after reset until then.
